bfly_stage_delay: RTL and testbench

Parametrised first-stage radix-2 DIF butterfly with an integrated delay buffer. A frame of LANES×2×HALF_BEATS complex points arrives LANES points per valid beat. The first half of the frame (A) is stored, and each beat of the second half (B) is combined lane-by-lane into A+B and A−B. It sits at the head of the FFT pipeline, directly after the input formatter. It adds gapped-valid tolerance, frame resync, optional per-frame scaling and output framing.

---
 rtl/bfly_pkg.sv | 42 ++++
 rtl/bfly_delay_buf.sv | 51 +++++
 rtl/bfly_stage_delay.sv | 242 ++++++++++++++++++++++++
 tb/tb_bfly_stage_delay.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfly_pkg.sv
// -----------------------------------------------------------------------------
// bfly_pkg
//
// Types and helpers shared by the butterfly stages of the FFT pipeline.
//
//   DEF_IN_W   default input component width of the pipeline head
//   DEF_OUT_W  default output component width (one growth bit)
//   RH_W       working width of round_half; wide enough for any stage
//   sample_t   one signed input component at DEF_IN_W
//   wide_t     one signed output component at DEF_OUT_W
//   state_e    frame FSM states of a delay-buffer butterfly stage
//   round_half halve with round-half-up: (x + 1) >>> 1
// -----------------------------------------------------------------------------
package bfly_pkg;

   localparam int DEF_IN_W  = 11;
   localparam int DEF_OUT_W = DEF_IN_W + 1;

   // Stages of any width share one rounding helper, so it works at a width
   // comfortably above every component width used in the pipeline.
   localparam int RH_W = 32;

   typedef logic signed [DEF_IN_W-1:0]  sample_t;
   typedef logic signed [DEF_OUT_W-1:0] wide_t;

   typedef enum logic [1:0] {
      IDLE,   // waiting for a frame start
      FILL,   // storing the A half of the frame
      PAIR    // combining each B beat with its stored A beat
   } state_e;

   // Halve with round-half-up. The caller sign-extends its operand to RH_W
   // and truncates the result back to its own width; a sum or difference of
   // two narrower values always fits again after halving, so the truncation
   // never loses information.
   function automatic logic signed [RH_W-1:0] round_half(
      input logic signed [RH_W-1:0] x
   );
      return (x + 1) >>> 1;
   endfunction

endpackage

// File: rtl/bfly_delay_buf.sv
// -----------------------------------------------------------------------------
// bfly_delay_buf
//
// Storage for the A half of a butterfly frame: HALF_BEATS entries, each
// holding LANES complex points of IN_W-bit signed components.
//
// Ports
//   clk      rising-edge clock
//   wr_en    write the current beat into entry wr_addr
//   wr_addr  write entry index
//   wr_r     real components to store, one per lane
//   wr_i     imaginary components to store, one per lane
//   rd_addr  read entry index (combinational read)
//   rd_r     real components of entry rd_addr
//   rd_i     imaginary components of entry rd_addr
// -----------------------------------------------------------------------------
module bfly_delay_buf #(
   parameter  int IN_W       = 11,
   parameter  int LANES      = 16,
   parameter  int HALF_BEATS = 16,
   localparam int ADDR_W     = $clog2(HALF_BEATS)
) (
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic signed [IN_W-1:0] wr_r [LANES],
   input  logic signed [IN_W-1:0] wr_i [LANES],
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic signed [IN_W-1:0] rd_r [LANES],
   output logic signed [IN_W-1:0] rd_i [LANES]
);

   logic signed [IN_W-1:0] mem_r_q [HALF_BEATS][LANES];
   logic signed [IN_W-1:0] mem_i_q [HALF_BEATS][LANES];

   // NOTE: the storage array has no reset on purpose. Every entry is written
   // during FILL before PAIR can read it, so reset would only add a clear
   // path to every flop of the array without changing any visible output.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r_q[wr_addr] <= wr_r;
         mem_i_q[wr_addr] <= wr_i;
      end
   end

   // Combinational read: the A beat is available in the same cycle as the
   // matching B beat, so the stage adds no latency beyond its output register.
   assign rd_r = mem_r_q[rd_addr];
   assign rd_i = mem_i_q[rd_addr];

endmodule

// File: rtl/bfly_stage_delay.sv
// -----------------------------------------------------------------------------
// bfly_stage_delay
//
// First radix-2 DIF butterfly stage of the FFT pipeline with its own delay
// buffer. A frame is 2*HALF_BEATS beats of LANES complex points. The first
// HALF_BEATS beats (A) are stored; each following beat (B) is combined lane by
// lane with the stored A beat of the same index into A+B and A-B. Results can
// optionally be halved (round half up) per frame.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   din_valid   input beat qualifier; low is a bubble and all state holds
//   din_sof     first beat of a frame (meaningful only with din_valid)
//   scale_en    halve this frame's results; sampled on the frame's first beat
//   din_r/i     input lanes, IN_W-bit signed components
//   dout_valid  one-cycle qualifier per B beat, one cycle after it arrives
//   dout_sof    marks the output of B beat 0
//   dout_idx    B beat index of the current output
//   dout_add_r/i  A+B per lane, OUT_W-bit signed
//   dout_sub_r/i  A-B per lane, OUT_W-bit signed
//   sof_err     one-cycle pulse after a frame is aborted by an early din_sof
// -----------------------------------------------------------------------------
module bfly_stage_delay
   import bfly_pkg::*;
#(
   parameter  int IN_W       = DEF_IN_W,
   parameter  int LANES      = 16,
   parameter  int HALF_BEATS = 16,
   localparam int OUT_W      = IN_W + 1,
   localparam int CNT_W      = $clog2(HALF_BEATS)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    din_valid,
   input  logic                    din_sof,
   input  logic                    scale_en,
   input  logic signed [IN_W-1:0]  din_r      [LANES],
   input  logic signed [IN_W-1:0]  din_i      [LANES],
   output logic                    dout_valid,
   output logic                    dout_sof,
   output logic [CNT_W-1:0]        dout_idx,
   output logic signed [OUT_W-1:0] dout_add_r [LANES],
   output logic signed [OUT_W-1:0] dout_add_i [LANES],
   output logic signed [OUT_W-1:0] dout_sub_r [LANES],
   output logic signed [OUT_W-1:0] dout_sub_i [LANES],
   output logic                    sof_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ------------------------------------------------------------------------
   // Frame control state
   // ------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             scale_q, scale_d;

   logic             wr_en;
   logic [CNT_W-1:0] wr_addr;
   logic             pair_fire;
   logic             abort;

   // ------------------------------------------------------------------------
   // Next-state logic
   //
   // A valid din_sof always starts a new frame at A[0], whatever the state.
   // From IDLE that is the normal start (including the back-to-back case,
   // since the last PAIR beat leaves the FSM in IDLE with cnt = 0). From
   // FILL or PAIR it abandons the partial frame: FILL never sits at cnt = 0,
   // and PAIR never legally begins with din_sof, so any sof seen there is an
   // abort. The restart beat is written to entry 0 explicitly because cnt_q
   // is nonzero in the abort case.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no
      // path through the case leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      scale_d   = scale_q;
      wr_en     = 1'b0;
      wr_addr   = cnt_q;
      pair_fire = 1'b0;
      abort     = 1'b0;

      if (din_valid) begin
         if (din_sof) begin
            abort   = (state_q != IDLE);
            wr_en   = 1'b1;
            wr_addr = '0;
            state_d = FILL;
            cnt_d   = CNT_ONE;
            scale_d = scale_en;
         end else begin
            case (state_q)
               IDLE: begin
                  // A beat outside any frame is dropped silently.
               end
               FILL: begin
                  wr_en = 1'b1;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_d = PAIR;
                  end
               end
               PAIR: begin
                  pair_fire = 1'b1;
                  cnt_d     = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_d = IDLE;
                  end
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only,
   // so every flop samples the values from before the clock edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         scale_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         scale_q <= scale_d;
      end
   end

   // ------------------------------------------------------------------------
   // A-half delay buffer, shared write/read index cnt
   // ------------------------------------------------------------------------
   logic signed [IN_W-1:0] a_r [LANES];
   logic signed [IN_W-1:0] a_i [LANES];

   bfly_delay_buf #(
      .IN_W       (IN_W),
      .LANES      (LANES),
      .HALF_BEATS (HALF_BEATS)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_r    (din_r),
      .wr_i    (din_i),
      .rd_addr (cnt_q),
      .rd_r    (a_r),
      .rd_i    (a_i)
   );

   // ------------------------------------------------------------------------
   // Per-lane butterfly arithmetic
   //
   // Operands are sign-extended by one bit, so A+B and A-B are exact in
   // OUT_W. When the frame is scaled, each result is halved with
   // round-half-up; halving an OUT_W value that came from IN_W operands
   // always fits back into OUT_W.
   // ------------------------------------------------------------------------
   logic signed [OUT_W-1:0] add_r_d [LANES];
   logic signed [OUT_W-1:0] add_i_d [LANES];
   logic signed [OUT_W-1:0] sub_r_d [LANES];
   logic signed [OUT_W-1:0] sub_i_d [LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [OUT_W-1:0] ax_r, ax_i, bx_r, bx_i;
      logic signed [OUT_W-1:0] s_r, s_i, d_r, d_i;

      assign ax_r = {a_r[l][IN_W-1], a_r[l]};
      assign ax_i = {a_i[l][IN_W-1], a_i[l]};
      assign bx_r = {din_r[l][IN_W-1], din_r[l]};
      assign bx_i = {din_i[l][IN_W-1], din_i[l]};

      assign s_r = ax_r + bx_r;
      assign s_i = ax_i + bx_i;
      assign d_r = ax_r - bx_r;
      assign d_i = ax_i - bx_i;

      assign add_r_d[l] = scale_q ? OUT_W'(round_half(RH_W'(s_r))) : s_r;
      assign add_i_d[l] = scale_q ? OUT_W'(round_half(RH_W'(s_i))) : s_i;
      assign sub_r_d[l] = scale_q ? OUT_W'(round_half(RH_W'(d_r))) : d_r;
      assign sub_i_d[l] = scale_q ? OUT_W'(round_half(RH_W'(d_i))) : d_i;
   end

   // ------------------------------------------------------------------------
   // Output registers
   //
   // Qualifiers follow the accepted PAIR beat by one cycle and are low
   // otherwise. Index and data only load on a PAIR beat, so they hold their
   // last value through bubbles and between frames.
   // ------------------------------------------------------------------------
   logic                    dout_valid_q;
   logic                    dout_sof_q;
   logic [CNT_W-1:0]        dout_idx_q;
   logic                    sof_err_q;
   logic signed [OUT_W-1:0] add_r_q [LANES];
   logic signed [OUT_W-1:0] add_i_q [LANES];
   logic signed [OUT_W-1:0] sub_r_q [LANES];
   logic signed [OUT_W-1:0] sub_i_q [LANES];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout_valid_q <= 1'b0;
         dout_sof_q   <= 1'b0;
         dout_idx_q   <= '0;
         sof_err_q    <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            add_r_q[l] <= '0;
            add_i_q[l] <= '0;
            sub_r_q[l] <= '0;
            sub_i_q[l] <= '0;
         end
      end else begin
         dout_valid_q <= pair_fire;
         dout_sof_q   <= pair_fire && (cnt_q == '0);
         sof_err_q    <= abort;
         if (pair_fire) begin
            dout_idx_q <= cnt_q;
            add_r_q    <= add_r_d;
            add_i_q    <= add_i_d;
            sub_r_q    <= sub_r_d;
            sub_i_q    <= sub_i_d;
         end
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout_sof   = dout_sof_q;
   assign dout_idx   = dout_idx_q;
   assign sof_err    = sof_err_q;
   assign dout_add_r = add_r_q;
   assign dout_add_i = add_i_q;
   assign dout_sub_r = sub_r_q;
   assign dout_sub_i = sub_i_q;

endmodule

// File: tb/tb_bfly_stage_delay.sv
// -----------------------------------------------------------------------------
// tb_bfly_stage_delay
//
// Directed bench for bfly_stage_delay at IN_W=11, LANES=16, HALF_BEATS=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the edge that registers them.
//
// Frame data (beat k, lane l, frame offset fo):
//   A: r = 100 + l + 4k + fo     i = -50 + l - k
//   B: r =  20 - l +  k          i =   7 + 2k
// giving, by hand:
//   add_r = 120 + 5k + fo        sub_r =  80 + 2l + 3k + fo
//   add_i = -43 + l + k          sub_i = -57 + l - 3k
// Scaled frames expect (x + 1) >>> 1 of each. Extreme-value frames use
// constant lanes with fully hand-written expectations.
// -----------------------------------------------------------------------------
module tb_bfly_stage_delay;

   localparam int IN_W  = 11;
   localparam int LANES = 16;
   localparam int HB    = 16;
   localparam int OUT_W = IN_W + 1;

   logic clk       = 1'b0;
   logic rstn      = 1'b0;
   logic din_valid = 1'b0;
   logic din_sof   = 1'b0;
   logic scale_en  = 1'b0;
   logic signed [IN_W-1:0]  din_r      [LANES];
   logic signed [IN_W-1:0]  din_i      [LANES];
   logic                    dout_valid;
   logic                    dout_sof;
   logic [3:0]              dout_idx;
   logic signed [OUT_W-1:0] dout_add_r [LANES];
   logic signed [OUT_W-1:0] dout_add_i [LANES];
   logic signed [OUT_W-1:0] dout_sub_r [LANES];
   logic signed [OUT_W-1:0] dout_sub_i [LANES];
   logic                    sof_err;

   bfly_stage_delay #(
      .IN_W       (IN_W),
      .LANES      (LANES),
      .HALF_BEATS (HB)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .din_valid  (din_valid),
      .din_sof    (din_sof),
      .scale_en   (scale_en),
      .din_r      (din_r),
      .din_i      (din_i),
      .dout_valid (dout_valid),
      .dout_sof   (dout_sof),
      .dout_idx   (dout_idx),
      .dout_add_r (dout_add_r),
      .dout_add_i (dout_add_i),
      .dout_sub_r (dout_sub_r),
      .dout_sub_i (dout_sub_i),
      .sof_err    (sof_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit frame_sc  = 1'b0;
   bit use_const = 1'b0;
   int ca, cb, e_add, e_sub;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic int rnd(input int x);
      return (x + 1) >>> 1;
   endfunction

   task automatic set_lanes(input bit is_b, input int k, input int fo);
      for (int l = 0; l < LANES; l++) begin
         if (use_const) begin
            din_r[l] = IN_W'(is_b ? cb : ca);
            din_i[l] = IN_W'(is_b ? cb : ca);
         end else if (!is_b) begin
            din_r[l] = IN_W'(100 + l + 4*k + fo);
            din_i[l] = IN_W'(-50 + l - k);
         end else begin
            din_r[l] = IN_W'(20 - l + k);
            din_i[l] = IN_W'(7 + 2*k);
         end
      end
   endtask

   task automatic check_lanes(input int k, input int fo);
      int ear, eai, esr, esi;
      for (int l = 0; l < LANES; l++) begin
         if (use_const) begin
            ear = e_add; eai = e_add; esr = e_sub; esi = e_sub;
         end else begin
            ear = 120 + 5*k + fo;
            esr = 80 + 2*l + 3*k + fo;
            eai = -43 + l + k;
            esi = -57 + l - 3*k;
            if (frame_sc) begin
               ear = rnd(ear); esr = rnd(esr); eai = rnd(eai); esi = rnd(esi);
            end
         end
         check($sformatf("add_r k%0d l%0d", k, l), 32'(dout_add_r[l]), ear);
         check($sformatf("add_i k%0d l%0d", k, l), 32'(dout_add_i[l]), eai);
         check($sformatf("sub_r k%0d l%0d", k, l), 32'(dout_sub_r[l]), esr);
         check($sformatf("sub_i k%0d l%0d", k, l), 32'(dout_sub_i[l]), esi);
      end
   endtask

   // One clock with the given inputs, then check what that edge registered.
   task automatic beat(input bit v, input bit sof, input bit sc, input bit is_b,
                       input int k, input int fo, input bit exp_out,
                       input bit exp_err);
      din_valid = v;
      din_sof   = sof;
      scale_en  = sc;
      set_lanes(is_b, k, fo);
      @(posedge clk);
      #1;
      check("dout_valid", 32'(dout_valid), 32'(exp_out));
      check("sof_err", 32'(sof_err), 32'(exp_err));
      if (exp_out) begin
         check($sformatf("dout_sof k%0d", k), 32'(dout_sof), 32'(k == 0));
         check($sformatf("dout_idx k%0d", k), 32'(dout_idx), k);
         check_lanes(k, fo);
      end else begin
         check("dout_sof quiet", 32'(dout_sof), 0);
      end
   endtask

   // Random bubbles; din_sof and data are scrambled since they must be ignored.
   task automatic gaps();
      int n;
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) begin
         din_valid = 1'b0;
         din_sof   = 1'($urandom_range(0, 1));
         scale_en  = 1'($urandom_range(0, 1));
         for (int l = 0; l < LANES; l++) begin
            din_r[l] = IN_W'($urandom);
            din_i[l] = IN_W'($urandom);
         end
         @(posedge clk);
         #1;
         check("bubble dout_valid", 32'(dout_valid), 0);
         check("bubble sof_err", 32'(sof_err), 0);
      end
   endtask

   // n_a A beats (first with sof) then n_b B beats. scale_en is driven to the
   // opposite value after the first beat so only the sampled value may count.
   task automatic run_frame(input bit sc, input int fo, input bit gapped,
                            input bit err_first, input int n_a, input int n_b);
      frame_sc = sc;
      for (int k = 0; k < n_a; k++) begin
         if (gapped) gaps();
         beat(1'b1, k == 0, (k == 0) ? sc : !sc, 1'b0, k, fo, 1'b0,
              err_first && (k == 0));
      end
      for (int k = 0; k < n_b; k++) begin
         if (gapped) gaps();
         beat(1'b1, 1'b0, !sc, 1'b1, k, fo, 1'b1, 1'b0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " dout_valid"}, 32'(dout_valid), 0);
      check({tag, " dout_sof"}, 32'(dout_sof), 0);
      check({tag, " dout_idx"}, 32'(dout_idx), 0);
      check({tag, " sof_err"}, 32'(sof_err), 0);
      for (int l = 0; l < LANES; l++) begin
         check($sformatf("%s add_r l%0d", tag, l), 32'(dout_add_r[l]), 0);
         check($sformatf("%s add_i l%0d", tag, l), 32'(dout_add_i[l]), 0);
         check($sformatf("%s sub_r l%0d", tag, l), 32'(dout_sub_r[l]), 0);
         check($sformatf("%s sub_i l%0d", tag, l), 32'(dout_sub_i[l]), 0);
      end
   endtask

   initial begin
      for (int l = 0; l < LANES; l++) begin
         din_r[l] = '0;
         din_i[l] = '0;
      end

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rstn = 1'b1;

      // Valid beats without sof in IDLE are dropped.
      beat(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
      beat(1'b1, 1'b0, 1'b1, 1'b0, 3, 0, 1'b0, 1'b0);

      // Single unscaled frame.
      run_frame(1'b0, 0, 1'b0, 1'b0, HB, HB);

      // Back-to-back frames, unscaled then scaled.
      run_frame(1'b0, 10, 1'b0, 1'b0, HB, HB);
      run_frame(1'b1, 20, 1'b0, 1'b0, HB, HB);

      // Extremes.
      use_const = 1'b1;
      ca = -1024; cb = -1024;
      e_add = -2048; e_sub = 0;
      run_frame(1'b0, 0, 1'b0, 1'b0, HB, HB);
      e_add = -1024; e_sub = 0;
      run_frame(1'b1, 0, 1'b0, 1'b0, HB, HB);
      ca = 1023; cb = -1024;
      e_add = -1; e_sub = 2047;
      run_frame(1'b0, 0, 1'b0, 1'b0, HB, HB);
      e_add = 0; e_sub = 1024;
      run_frame(1'b1, 0, 1'b0, 1'b0, HB, HB);
      use_const = 1'b0;

      // Gapped scaled frame.
      run_frame(1'b1, 30, 1'b1, 1'b0, HB, HB);

      // Early sof at FILL beat 7: aborted frame yields nothing, new one is clean.
      run_frame(1'b0, 200, 1'b0, 1'b0, 7, 0);
      run_frame(1'b1, 40, 1'b0, 1'b1, HB, HB);

      // Sof during PAIR is an abort too.
      run_frame(1'b1, 70, 1'b0, 1'b0, HB, 3);
      run_frame(1'b0, 80, 1'b0, 1'b1, HB, HB);

      // Reset during PAIR beat 5.
      run_frame(1'b0, 50, 1'b0, 1'b0, HB, 5);
      din_valid = 1'b1;
      din_sof   = 1'b0;
      set_lanes(1'b1, 5, 50);
      #3;
      rstn = 1'b0;
      #1;
      check_all_zero("mid-frame reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      beat(1'b1, 1'b0, 1'b0, 1'b1, 6, 50, 1'b0, 1'b0);
      beat(1'b1, 1'b0, 1'b0, 1'b1, 7, 50, 1'b0, 1'b0);
      check("post-reset add_r hold", 32'(dout_add_r[3]), 0);
      run_frame(1'b0, 90, 1'b0, 1'b0, HB, HB);

      din_valid = 1'b0;
      din_sof   = 1'b0;
      @(posedge clk);
      #1;
      check("idle dout_valid", 32'(dout_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
